// File: rtl/nanocore_btb_pkg.sv
// Shared NanoCore branch-prediction types and sizing constants.
// Used by the BTB top, its static-jump sub-table and the testbench.
package NanoCore_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int SBP_ENTRIES = 4;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int SBP_IDX_W   = $clog2(SBP_ENTRIES);

  localparam logic [1:0] BHT_INIT_T = 2'b10;
  localparam logic [1:0] BHT_INIT_N = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic [1:0]  bht;
  } btb_t;

  typedef struct packed {
    logic                 insert_btb;
    logic                 update_bht;
    logic                 inc_bht;
    logic                 update_tgt;
    logic [BTB_IDX_W-1:0] entryID;
    logic [15:0]          pc;
    logic [15:0]          tgt;
  } btb_update_t;

  typedef struct packed {
    logic                 hit;
    logic                 sbp_hit;
    logic                 jump;
    logic [15:0]          tgt;
    logic [15:0]          pc;
    logic [BTB_IDX_W-1:0] entryID;
  } btb_ctl_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] tgt;
  } sbp_t;

  typedef struct packed {
    logic [15:0] tgt;
    logic [15:0] pc;
  } sbp_update_t;

  // Two-bit saturating counter step used for branch history training.
  function automatic logic [1:0] bhtStep(input logic [1:0] cur, input logic inc);
    if (inc) return (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    else     return (cur == 2'b00) ? 2'b00 : cur - 2'b01;
  endfunction

endpackage

// File: rtl/nanocore_btb_sbp.sv
// Static-jump table for resolved JAL targets: combinational match, dedup-or-round-robin insert.
module nanocore_btb_sbp
  import NanoCore_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [15:0] lookup_pc_i,
  input  logic        upd_v_i,
  input  sbp_update_t upd_i,
  output logic        hit_o,
  output logic [15:0] tgt_o
);

  sbp_t                 sbp_q [SBP_ENTRIES];
  sbp_t                 sbp_d [SBP_ENTRIES];
  logic [SBP_IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic                 dupHit;
  logic [SBP_IDX_W-1:0] dupIdx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_o  = 1'b0;
    tgt_o  = '0;
    dupHit = 1'b0;
    dupIdx = '0;
    for (int i = SBP_ENTRIES - 1; i >= 0; i--) begin
      if (sbp_q[i].valid && sbp_q[i].pc == lookup_pc_i) begin
        hit_o = 1'b1;
        tgt_o = sbp_q[i].tgt;
      end
      if (sbp_q[i].valid && sbp_q[i].pc == upd_i.pc) begin
        dupHit = 1'b1;
        dupIdx = SBP_IDX_W'(i);
      end
    end
  end

  always_comb begin
    sbp_d   = sbp_q;
    rrPtr_d = rrPtr_q;
    if (flush_i) begin
      for (int i = 0; i < SBP_ENTRIES; i++) sbp_d[i] = '0;
      rrPtr_d = '0;
    end else if (upd_v_i) begin
      if (dupHit) begin
        sbp_d[dupIdx] = '{valid: 1'b1, pc: upd_i.pc, tgt: upd_i.tgt};
      end else begin
        sbp_d[rrPtr_q] = '{valid: 1'b1, pc: upd_i.pc, tgt: upd_i.tgt};
        rrPtr_d        = rrPtr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SBP_ENTRIES; i++) sbp_q[i] <= '0;
      rrPtr_q <= '0;
    end else begin
      sbp_q   <= sbp_d;
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/nanocore_btb.sv
// NanoCore fetch-stage branch target buffer: 16-way associative BTB with 2-bit BHT,
// backed by a static-jump table, producing a registered prediction one cycle after lookup.
module nanocore_btb
  import NanoCore_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_lookup_v,
  input  logic [15:0] i_lookup_pc,
  output logic        o_btb_ctl_v,
  output btb_ctl_t    o_btb_ctl,
  input  logic        i_upd_v,
  input  btb_update_t i_upd,
  input  logic        i_sbp_upd_v,
  input  sbp_update_t i_sbp_upd,
  input  logic        i_flush
);

  btb_t                 btb_q [BTB_ENTRIES];
  btb_t                 btb_d [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0] rrPtr_q, rrPtr_d;
  btb_ctl_t             ctl_q, ctl_d;
  logic                 ctlValid_q;

  logic                 hitAny;
  logic [BTB_IDX_W-1:0] hitIdx;
  logic                 dupHit;
  logic [BTB_IDX_W-1:0] dupIdx;
  logic                 sbpHit;
  logic [15:0]          sbpTgt;

  nanocore_btb_sbp u_sbp (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (i_flush),
    .lookup_pc_i (i_lookup_pc),
    .upd_v_i     (i_sbp_upd_v),
    .upd_i       (i_sbp_upd),
    .hit_o       (sbpHit),
    .tgt_o       (sbpTgt)
  );

  // Parallel compare for lookup and insert-dedup; descending scan gives lowest-index priority.
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    dupHit = 1'b0;
    dupIdx = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (btb_q[i].valid && btb_q[i].pc == i_lookup_pc) begin
        hitAny = 1'b1;
        hitIdx = BTB_IDX_W'(i);
      end
      if (btb_q[i].valid && btb_q[i].pc == i_upd.pc) begin
        dupHit = 1'b1;
        dupIdx = BTB_IDX_W'(i);
      end
    end
  end

  // Prediction reads the pre-update table; a flush in the same cycle forces a miss.
  always_comb begin
    ctl_d = ctl_q;
    if (i_lookup_v) begin
      ctl_d    = '0;
      ctl_d.pc = i_lookup_pc;
      if (!i_flush) begin
        ctl_d.hit     = hitAny;
        ctl_d.sbp_hit = sbpHit;
        if (hitAny) begin
          ctl_d.entryID = hitIdx;
          ctl_d.tgt     = btb_q[hitIdx].tgt;
          ctl_d.jump    = btb_q[hitIdx].bht[1];
        end else if (sbpHit) begin
          ctl_d.tgt  = sbpTgt;
          ctl_d.jump = 1'b1;
        end
      end
    end
  end

  always_comb begin
    btb_d   = btb_q;
    rrPtr_d = rrPtr_q;
    if (i_flush) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        btb_d[i] = '{valid: 1'b0, pc: '0, tgt: '0, bht: BHT_INIT_N};
      rrPtr_d = '0;
    end else if (i_upd_v && i_upd.insert_btb) begin
      if (dupHit) begin
        btb_d[dupIdx] = '{valid: 1'b1, pc: i_upd.pc, tgt: i_upd.tgt,
                          bht: i_upd.inc_bht ? BHT_INIT_T : BHT_INIT_N};
      end else begin
        btb_d[rrPtr_q] = '{valid: 1'b1, pc: i_upd.pc, tgt: i_upd.tgt,
                           bht: i_upd.inc_bht ? BHT_INIT_T : BHT_INIT_N};
        rrPtr_d        = rrPtr_q + 1'b1;
      end
    end else if (i_upd_v && btb_q[i_upd.entryID].valid) begin
      if (i_upd.update_bht)
        btb_d[i_upd.entryID].bht = bhtStep(btb_q[i_upd.entryID].bht, i_upd.inc_bht);
      if (i_upd.update_tgt)
        btb_d[i_upd.entryID].tgt = i_upd.tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        btb_q[i] <= '{valid: 1'b0, pc: '0, tgt: '0, bht: BHT_INIT_N};
      rrPtr_q    <= '0;
      ctl_q      <= '0;
      ctlValid_q <= 1'b0;
    end else begin
      btb_q      <= btb_d;
      rrPtr_q    <= rrPtr_d;
      ctl_q      <= ctl_d;
      ctlValid_q <= i_lookup_v;
    end
  end

  assign o_btb_ctl_v = ctlValid_q;
  assign o_btb_ctl   = ctl_q;

endmodule

// File: tb/tb_nanocore_btb.sv
// Scoreboard bench for nanocore_btb: directed lookups push expected predictions,
// a negedge monitor pops and compares every valid output.
module tb_nanocore_btb;
  import NanoCore_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_lookup_v = 1'b0;
  logic [15:0] i_lookup_pc = '0;
  logic        o_btb_ctl_v;
  btb_ctl_t    o_btb_ctl;
  logic        i_upd_v = 1'b0;
  btb_update_t i_upd = '0;
  logic        i_sbp_upd_v = 1'b0;
  sbp_update_t i_sbp_upd = '0;
  logic        i_flush = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  btb_ctl_t expQ [$];
  string    nameQ [$];

  nanocore_btb dut (
    .clk         (clk),
    .rst         (rst),
    .i_lookup_v  (i_lookup_v),
    .i_lookup_pc (i_lookup_pc),
    .o_btb_ctl_v (o_btb_ctl_v),
    .o_btb_ctl   (o_btb_ctl),
    .i_upd_v     (i_upd_v),
    .i_upd       (i_upd),
    .i_sbp_upd_v (i_sbp_upd_v),
    .i_sbp_upd   (i_sbp_upd),
    .i_flush     (i_flush)
  );

  always #5 clk = ~clk;

  function automatic btb_ctl_t mkCtl(input logic hit, input logic sbp, input logic jump,
                                     input logic [15:0] tgt, input logic [15:0] pc,
                                     input logic [3:0] id);
    btb_ctl_t c;
    c = '{hit: hit, sbp_hit: sbp, jump: jump, tgt: tgt, pc: pc, entryID: id};
    return c;
  endfunction

  function automatic btb_update_t mkIns(input logic [15:0] pc, input logic [15:0] tgt,
                                        input logic inc);
    btb_update_t u;
    u = '0;
    u.insert_btb = 1'b1;
    u.inc_bht = inc;
    u.pc = pc;
    u.tgt = tgt;
    return u;
  endfunction

  function automatic btb_update_t mkTrain(input logic [3:0] id, input logic updBht,
                                          input logic inc, input logic updTgt,
                                          input logic [15:0] tgt);
    btb_update_t u;
    u = '0;
    u.entryID = id;
    u.update_bht = updBht;
    u.inc_bht = inc;
    u.update_tgt = updTgt;
    u.tgt = tgt;
    return u;
  endfunction

  function automatic sbp_update_t mkSbp(input logic [15:0] pc, input logic [15:0] tgt);
    sbp_update_t s;
    s = '{tgt: tgt, pc: pc};
    return s;
  endfunction

  // Drives one cycle of inputs; an expected prediction is queued when a lookup is issued.
  task automatic applyStimulus(input logic lv, input logic [15:0] lpc,
                               input logic uv, input btb_update_t u,
                               input logic sv, input sbp_update_t s,
                               input logic fl, input logic expOn,
                               input btb_ctl_t expCtl, input string name);
    i_lookup_v  = lv;
    i_lookup_pc = lpc;
    i_upd_v     = uv;
    i_upd       = u;
    i_sbp_upd_v = sv;
    i_sbp_upd   = s;
    i_flush     = fl;
    if (expOn) begin
      expQ.push_back(expCtl);
      nameQ.push_back(name);
    end
    @(posedge clk);
    #1;
    i_lookup_v  = 1'b0;
    i_upd_v     = 1'b0;
    i_sbp_upd_v = 1'b0;
    i_flush     = 1'b0;
  endtask

  task automatic lookup(input logic [15:0] pc, input btb_ctl_t expCtl, input string name);
    applyStimulus(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, expCtl, name);
  endtask

  task automatic upd(input btb_update_t u);
    applyStimulus(1'b0, '0, 1'b1, u, 1'b0, '0, 1'b0, 1'b0, '0, "");
  endtask

  task automatic sbpIns(input logic [15:0] pc, input logic [15:0] tgt);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, mkSbp(pc, tgt), 1'b0, 1'b0, '0, "");
  endtask

  task automatic flush();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, "");
  endtask

  task automatic checkOutput(input string name, input btb_ctl_t act, input btb_ctl_t req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got hit=%0b sbp=%0b jump=%0b tgt=%h pc=%h id=%0d, want hit=%0b sbp=%0b jump=%0b tgt=%h pc=%h id=%0d",
               name, act.hit, act.sbp_hit, act.jump, act.tgt, act.pc, act.entryID,
               req.hit, req.sbp_hit, req.jump, req.tgt, req.pc, req.entryID);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0b, want %0b", name, act, req);
    end
  endtask

  // Monitor: every valid prediction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && o_btb_ctl_v) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_output: got valid prediction pc=%h, want none", o_btb_ctl.pc);
      end else begin
        checkOutput(nameQ.pop_front(), o_btb_ctl, expQ.pop_front());
      end
    end
  end

  initial begin
    btb_ctl_t lastCtl;

    repeat (3) @(posedge clk);
    #1;
    checkBit("reset_valid", o_btb_ctl_v, 1'b0);
    checkOutput("reset_ctl", o_btb_ctl, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    lookup(16'h0100, mkCtl(0, 0, 0, 16'h0000, 16'h0100, 0), "cold_miss");

    upd(mkIns(16'h0100, 16'h0200, 1'b1));
    lookup(16'h0100, mkCtl(1, 0, 1, 16'h0200, 16'h0100, 0), "insert_hit");

    upd(mkTrain(0, 1, 0, 0, 16'h0000));
    upd(mkTrain(0, 1, 0, 0, 16'h0000));
    lookup(16'h0100, mkCtl(1, 0, 0, 16'h0200, 16'h0100, 0), "bht_dec_to_0");
    upd(mkTrain(0, 1, 0, 0, 16'h0000));
    upd(mkTrain(0, 1, 1, 0, 16'h0000));
    lookup(16'h0100, mkCtl(1, 0, 0, 16'h0200, 16'h0100, 0), "bht_floor_then_inc");
    for (int k = 0; k < 3; k++) upd(mkTrain(0, 1, 1, 0, 16'h0000));
    lookup(16'h0100, mkCtl(1, 0, 1, 16'h0200, 16'h0100, 0), "bht_inc_sat");
    upd(mkTrain(0, 1, 0, 0, 16'h0000));
    lookup(16'h0100, mkCtl(1, 0, 1, 16'h0200, 16'h0100, 0), "bht_sat_then_dec");

    flush();
    for (int k = 0; k < 17; k++)
      upd(mkIns(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0));
    lookup(16'h1000, mkCtl(0, 0, 0, 16'h0000, 16'h1000, 0), "rr_evicted");
    lookup(16'h1010, mkCtl(1, 0, 0, 16'h2010, 16'h1010, 0), "rr_wrap_slot0");
    lookup(16'h1005, mkCtl(1, 0, 0, 16'h2005, 16'h1005, 5), "rr_slot5");

    upd(mkIns(16'h1005, 16'h3005, 1'b1));
    upd(mkIns(16'h7777, 16'h8888, 1'b0));
    lookup(16'h1005, mkCtl(1, 0, 1, 16'h3005, 16'h1005, 5), "dedup_overwrite");
    lookup(16'h7777, mkCtl(1, 0, 0, 16'h8888, 16'h7777, 1), "dedup_no_alloc");
    lookup(16'h1001, mkCtl(0, 0, 0, 16'h0000, 16'h1001, 0), "dedup_next_evict");

    sbpIns(16'h0300, 16'h0400);
    lookup(16'h0300, mkCtl(0, 1, 1, 16'h0400, 16'h0300, 0), "sbp_only_hit");
    sbpIns(16'h1005, 16'h5555);
    lookup(16'h1005, mkCtl(1, 1, 1, 16'h3005, 16'h1005, 5), "btb_over_sbp");

    applyStimulus(1'b1, 16'h1010, 1'b1, mkTrain(0, 0, 0, 1, 16'hABCD), 1'b0, '0, 1'b0,
                  1'b1, mkCtl(1, 0, 0, 16'h2010, 16'h1010, 0), "read_before_write");
    lookup(16'h1010, mkCtl(1, 0, 0, 16'hABCD, 16'h1010, 0), "tgt_updated");

    applyStimulus(1'b1, 16'h1010, 1'b1, mkIns(16'h4444, 16'h5555, 1'b1), 1'b1,
                  mkSbp(16'h0A0A, 16'h0B0B), 1'b1, 1'b1,
                  mkCtl(0, 0, 0, 16'h0000, 16'h1010, 0), "flush_same_cycle");
    lookup(16'h4444, mkCtl(0, 0, 0, 16'h0000, 16'h4444, 0), "flush_beats_insert");
    lookup(16'h0A0A, mkCtl(0, 0, 0, 16'h0000, 16'h0A0A, 0), "flush_beats_sbp");
    lookup(16'h0300, mkCtl(0, 0, 0, 16'h0000, 16'h0300, 0), "flush_clears_sbp");
    lookup(16'h1005, mkCtl(0, 0, 0, 16'h0000, 16'h1005, 0), "flush_clears_btb");

    for (int k = 0; k < 5; k++)
      sbpIns(16'h0A00 + 16'(k), 16'h0A01 + 16'(k));
    lookup(16'h0A00, mkCtl(0, 0, 0, 16'h0000, 16'h0A00, 0), "sbp_rr_evict");
    lookup(16'h0A04, mkCtl(0, 1, 1, 16'h0A05, 16'h0A04, 0), "sbp_rr_wrap");
    lookup(16'h0A01, mkCtl(0, 1, 1, 16'h0A02, 16'h0A01, 0), "sbp_rr_keep");
    lastCtl = mkCtl(0, 1, 1, 16'h0A02, 16'h0A01, 0);

    @(posedge clk);
    #1;
    checkBit("idle_valid_low", o_btb_ctl_v, 1'b0);
    checkOutput("idle_hold", o_btb_ctl, lastCtl);

    applyStimulus(1'b1, 16'h0A04, 1'b1, mkIns(16'h0A04, 16'h1111, 1'b1), 1'b0, '0, 1'b0,
                  1'b0, '0, "");
    #1;
    rst = 1'b1;
    #1;
    checkBit("async_reset_valid", o_btb_ctl_v, 1'b0);
    checkOutput("async_reset_ctl", o_btb_ctl, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lookup(16'h0A04, mkCtl(0, 0, 0, 16'h0000, 16'h0A04, 0), "reset_clears_state");

    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending_expectations: got %0d outstanding, want 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
